// File: rtl/prog_seq_pkg.sv
// Shared types and defaults for the program sequencer.
package prog_seq_pkg;

  typedef enum logic [2:0] {IDLE, CRST, LOAD, START, RUN, NEXT, FINISH} seq_state_t;

  localparam int unsigned NumProgsDefault = 3;
  localparam int unsigned PcWDefault      = 10;
  localparam int unsigned CntWDefault     = 16;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_base_table.sv
// Per-program base-address register file; writes are blocked while the sequencer is busy.
module prog_base_table
  import prog_seq_pkg::*;
#(
  parameter int unsigned NUM_PROGS = NumProgsDefault,
  parameter int unsigned PC_W      = PcWDefault
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                busy,
  input  logic                                we,
  input  logic [idx_width(NUM_PROGS)-1:0]     widx,
  input  logic [PC_W-1:0]                     wdata,
  input  logic [idx_width(NUM_PROGS)-1:0]     ridx,
  output logic [PC_W-1:0]                     rdata
);

  localparam int unsigned IdxW = idx_width(NUM_PROGS);

  logic [PC_W-1:0] base_q [NUM_PROGS];

  // Out-of-range indices match no entry, so they are dropped naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROGS; i++) base_q[i] <= '0;
    end else if (we && !busy) begin
      for (int i = 0; i < NUM_PROGS; i++) begin
        if (widx == IdxW'(i)) base_q[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (ridx == IdxW'(i)) rdata = base_q[i];
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program controller: reset, jump, start and run each program in turn with a timeout.
// Optional per-program cycle log enabled by defining PROG_SEQ_CYCLE_LOG_EN.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned NUM_PROGS = NumProgsDefault,
  parameter int unsigned PC_W      = PcWDefault,
  parameter int unsigned CNT_W     = CntWDefault
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              Go,
  input  logic                              Done,
  input  logic                              CfgWe,
  input  logic [idx_width(NUM_PROGS)-1:0]   CfgIdx,
  input  logic [PC_W-1:0]                   CfgAddr,
  output logic                              CoreReset,
  output logic                              CoreStart,
  output logic                              SeqJump,
  output logic                              SeqAbsRel,
  output logic [PC_W-1:0]                   SeqTarget,
  output logic [idx_width(NUM_PROGS)-1:0]   ProgIdx,
  output logic [CNT_W-1:0]                  CycleCnt,
  output logic                              Busy,
  output logic                              AllDone,
  output logic                              Timeout
`ifdef PROG_SEQ_CYCLE_LOG_EN
  ,
  input  logic [idx_width(NUM_PROGS)-1:0]   LogIdx,
  output logic [CNT_W-1:0]                  LogCnt
`endif
);

  localparam int unsigned IdxW = idx_width(NUM_PROGS);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_PROGS - 1);

  seq_state_t        state_q;
  logic              core_reset_q, core_start_q, seq_jump_q;
  logic [PC_W-1:0]   seq_target_q;
  logic [IdxW-1:0]   prog_idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, all_done_q, timeout_q;
  logic [PC_W-1:0]   base_rdata;

  prog_base_table #(
    .NUM_PROGS (NUM_PROGS),
    .PC_W      (PC_W)
  ) u_base_table (
    .clk   (Clk),
    .rst_n (Reset_n),
    .busy  (busy_q),
    .we    (CfgWe),
    .widx  (CfgIdx),
    .wdata (CfgAddr),
    .ridx  (prog_idx_q),
    .rdata (base_rdata)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      core_reset_q <= 1'b0;
      core_start_q <= 1'b0;
      seq_jump_q   <= 1'b0;
      seq_target_q <= '0;
      prog_idx_q   <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      core_reset_q <= 1'b0;
      core_start_q <= 1'b0;
      seq_jump_q   <= 1'b0;
      unique case (state_q)
        IDLE, FINISH: begin
          if (Go) begin
            state_q      <= CRST;
            prog_idx_q   <= '0;
            timeout_q    <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            all_done_q   <= 1'b0;
          end
        end
        CRST: begin
          state_q      <= LOAD;
          seq_jump_q   <= 1'b1;
          seq_target_q <= base_rdata;
        end
        LOAD: begin
          state_q      <= START;
          core_start_q <= 1'b1;
        end
        START: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
        RUN: begin
          // Done takes priority over the timeout check in the same cycle.
          if (Done) begin
            state_q <= NEXT;
            cnt_q   <= (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
          end else if (cnt_q == CntMax) begin
            state_q    <= FINISH;
            timeout_q  <= 1'b1;
            busy_q     <= 1'b0;
            all_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        NEXT: begin
          if (prog_idx_q == LastIdx) begin
            state_q    <= FINISH;
            busy_q     <= 1'b0;
            all_done_q <= 1'b1;
          end else begin
            state_q      <= CRST;
            prog_idx_q   <= prog_idx_q + IdxW'(1);
            core_reset_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CoreReset = core_reset_q;
  assign CoreStart = core_start_q;
  assign SeqJump   = seq_jump_q;
  assign SeqAbsRel = 1'b0;
  assign SeqTarget = seq_target_q;
  assign ProgIdx   = prog_idx_q;
  assign CycleCnt  = cnt_q;
  assign Busy      = busy_q;
  assign AllDone   = all_done_q;
  assign Timeout   = timeout_q;

`ifdef PROG_SEQ_CYCLE_LOG_EN
  logic [CNT_W-1:0] log_q [NUM_PROGS];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_PROGS; i++) log_q[i] <= '0;
    end else if ((state_q == IDLE || state_q == FINISH) && Go) begin
      for (int i = 0; i < NUM_PROGS; i++) log_q[i] <= '0;
    end else if (state_q == NEXT || (state_q == RUN && !Done && cnt_q == CntMax)) begin
      for (int i = 0; i < NUM_PROGS; i++) begin
        if (prog_idx_q == IdxW'(i)) log_q[i] <= cnt_q;
      end
    end
  end

  always_comb begin
    LogCnt = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (LogIdx == IdxW'(i)) LogCnt = log_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer; log checks only when PROG_SEQ_CYCLE_LOG_EN is defined.
module tb_prog_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance, default widths.
  logic        go, done, cfg_we;
  logic [1:0]  cfg_idx;
  logic [9:0]  cfg_addr;
  logic        core_reset, core_start, seq_jump, seq_abs_rel, busy, all_done, timeout;
  logic [9:0]  seq_target;
  logic [1:0]  prog_idx;
  logic [15:0] cycle_cnt;

  // Short-counter instance for timeout scenarios.
  logic        go_t, done_t, cfg_we_t;
  logic [1:0]  cfg_idx_t;
  logic [9:0]  cfg_addr_t;
  logic        core_reset_t, core_start_t, seq_jump_t, seq_abs_rel_t, busy_t, all_done_t;
  logic        timeout_t;
  logic [9:0]  seq_target_t;
  logic [1:0]  prog_idx_t;
  logic [3:0]  cycle_cnt_t;

`ifdef PROG_SEQ_CYCLE_LOG_EN
  logic [1:0]  log_idx, log_idx_t;
  logic [15:0] log_cnt;
  logic [3:0]  log_cnt_t;
`endif

  prog_sequencer dut (
    .Clk(clk), .Reset_n(rst_n), .Go(go), .Done(done), .CfgWe(cfg_we), .CfgIdx(cfg_idx),
    .CfgAddr(cfg_addr), .CoreReset(core_reset), .CoreStart(core_start), .SeqJump(seq_jump),
    .SeqAbsRel(seq_abs_rel), .SeqTarget(seq_target), .ProgIdx(prog_idx),
    .CycleCnt(cycle_cnt), .Busy(busy), .AllDone(all_done), .Timeout(timeout)
`ifdef PROG_SEQ_CYCLE_LOG_EN
    , .LogIdx(log_idx), .LogCnt(log_cnt)
`endif
  );

  prog_sequencer #(.CNT_W(4)) dut_t (
    .Clk(clk), .Reset_n(rst_n), .Go(go_t), .Done(done_t), .CfgWe(cfg_we_t),
    .CfgIdx(cfg_idx_t), .CfgAddr(cfg_addr_t), .CoreReset(core_reset_t),
    .CoreStart(core_start_t), .SeqJump(seq_jump_t), .SeqAbsRel(seq_abs_rel_t),
    .SeqTarget(seq_target_t), .ProgIdx(prog_idx_t), .CycleCnt(cycle_cnt_t),
    .Busy(busy_t), .AllDone(all_done_t), .Timeout(timeout_t)
`ifdef PROG_SEQ_CYCLE_LOG_EN
    , .LogIdx(log_idx_t), .LogCnt(log_cnt_t)
`endif
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: base table contents and per-program run lengths.
  logic [9:0] model_base [3];
  int         lens [3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic [9:0] addr);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = addr;
    step();
    cfg_we = 1'b0;
    if (idx < 3) model_base[idx] = addr;
  endtask

  // One full series on the main instance. rst_prog >= 0 aborts with a reset in that program.
  task automatic run_series(input bit hold_done, input bit busy_write, input int rst_prog);
    int len;
    done = hold_done;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int p = 0; p < 3; p++) begin
      n_total++;
      if (core_reset !== 1'b1 || prog_idx !== 2'(p) || busy !== 1'b1 || all_done !== 1'b0) begin
        n_bad++;
        $display("FAIL crst p%0d: rst=%b idx=%0d busy=%b done=%b, want rst=1 idx=%0d busy=1 done=0",
                 p, core_reset, prog_idx, busy, all_done, p);
      end
      step();
      n_total++;
      if (seq_jump !== 1'b1 || seq_abs_rel !== 1'b0 || seq_target !== model_base[p] ||
          core_reset !== 1'b0) begin
        n_bad++;
        $display("FAIL load p%0d: jump=%b rel=%b target=%h rst=%b, want jump=1 rel=0 target=%h",
                 p, seq_jump, seq_abs_rel, seq_target, core_reset, model_base[p]);
      end
      if (busy_write) begin
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_addr = 10'h3FF;
      end
      step();
      cfg_we = 1'b0;
      n_total++;
      if (core_start !== 1'b1 || seq_jump !== 1'b0) begin
        n_bad++;
        $display("FAIL start p%0d: start=%b jump=%b, want start=1 jump=0", p, core_start, seq_jump);
      end
      step();
      len = hold_done ? 1 : lens[p];
      for (int k = 1; k <= len; k++) begin
        if (k == 1) begin
          n_total++;
          if (cycle_cnt !== 16'd0 || core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL run1 p%0d: cnt=%0d start=%b, want cnt=0 start=0", p, cycle_cnt,
                     core_start);
          end
        end
        if (p == rst_prog && k == 2) begin
          #2 rst_n = 1'b0;
          #1;
          n_total++;
          if ({core_reset, core_start, seq_jump, seq_abs_rel, busy, all_done, timeout} !== 7'b0 ||
              seq_target !== 10'd0 || prog_idx !== 2'd0 || cycle_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset: ctl=%b target=%h idx=%0d cnt=%0d, want all zero",
                     {core_reset, core_start, seq_jump, seq_abs_rel, busy, all_done, timeout},
                     seq_target, prog_idx, cycle_cnt);
          end
          step();
          rst_n = 1'b1;
          done = 1'b0;
          for (int i = 0; i < 3; i++) model_base[i] = '0;
          return;
        end
        if (!hold_done) done = (k == len);
        step();
      end
      done = hold_done;
      n_total++;
      if (cycle_cnt !== 16'(len) || busy !== 1'b1 || core_reset !== 1'b0) begin
        n_bad++;
        $display("FAIL next p%0d: cnt=%0d busy=%b rst=%b, want cnt=%0d busy=1 rst=0",
                 p, cycle_cnt, busy, core_reset, len);
      end
      step();
    end
    n_total++;
    if (all_done !== 1'b1 || busy !== 1'b0 || prog_idx !== 2'd2 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL finish: all_done=%b busy=%b idx=%0d timeout=%b, want 1 0 2 0",
               all_done, busy, prog_idx, timeout);
    end
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({core_reset, core_start, seq_jump, busy, all_done, timeout, busy_t} !== 7'b0 ||
        prog_idx !== 2'd0 || cycle_cnt !== 16'd0 || seq_target !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_state: ctl=%b idx=%0d cnt=%0d target=%h, want all zero",
               {core_reset, core_start, seq_jump, busy, all_done, timeout, busy_t},
               prog_idx, cycle_cnt, seq_target);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    cfg_write(0, 10'h000);
    cfg_write(1, 10'h120);
    cfg_write(2, 10'h2A0);
    cfg_write(3, 10'h155);
    lens[0] = 5; lens[1] = 7; lens[2] = 9;
    run_series(1'b0, 1'b1, -1);
  endtask

`ifdef PROG_SEQ_CYCLE_LOG_EN
  task automatic test_log();
    int cyc;
    for (int i = 0; i < 3; i++) begin
      log_idx = 2'(i);
      #1;
      n_total++;
      if (log_cnt !== 16'(lens[i])) begin
        n_bad++;
        $display("FAIL log%0d: got %0d want %0d", i, log_cnt, lens[i]);
      end
    end
    go = 1'b1;
    step();
    go = 1'b0;
    log_idx = 2'd0;
    #1;
    n_total++;
    if (log_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL log_clear: got %0d want 0", log_cnt);
    end
    done = 1'b1;
    cyc = 0;
    while (all_done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    done = 1'b0;
    n_total++;
    if (all_done !== 1'b1) begin
      n_bad++;
      $display("FAIL log_drain: all_done=%b want 1", all_done);
    end
  endtask
`endif

  task automatic test_done_hold();
    run_series(1'b1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        cfg_write(i, 10'($urandom_range(0, 1023)));
        lens[i] = int'($urandom_range(1, 12));
      end
      run_series(1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit saw_crst;
    done_t = 1'b0;
    go_t = 1'b1;
    step();
    go_t = 1'b0;
    step(); step(); step();
    // Done in the cycle the short counter sits at all-ones: Done must win.
    for (int k = 1; k <= 16; k++) begin
      done_t = (k == 16);
      step();
    end
    done_t = 1'b0;
    n_total++;
    if (cycle_cnt_t !== 4'd15 || timeout_t !== 1'b0) begin
      n_bad++;
      $display("FAIL done_wins: cnt=%0d timeout=%b, want cnt=15 timeout=0", cycle_cnt_t,
               timeout_t);
    end
    step();
    n_total++;
    if (core_reset_t !== 1'b1 || prog_idx_t !== 2'd1) begin
      n_bad++;
      $display("FAIL to_prog1: rst=%b idx=%0d, want rst=1 idx=1", core_reset_t, prog_idx_t);
    end
    step(); step(); step();
    cyc = 0;
    saw_crst = 1'b0;
    while (all_done_t !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
      if (core_reset_t === 1'b1) saw_crst = 1'b1;
    end
    n_total++;
    if (cyc != 16 || timeout_t !== 1'b1 || prog_idx_t !== 2'd1 || cycle_cnt_t !== 4'd15 ||
        busy_t !== 1'b0 || saw_crst) begin
      n_bad++;
      $display("FAIL timeout: cycles=%0d to=%b idx=%0d cnt=%0d busy=%b crst=%b, want 16 1 1 15 0 0",
               cyc, timeout_t, prog_idx_t, cycle_cnt_t, busy_t, saw_crst);
    end
`ifdef PROG_SEQ_CYCLE_LOG_EN
    for (int i = 0; i < 2; i++) begin
      log_idx_t = 2'(i);
      #1;
      n_total++;
      if (log_cnt_t !== 4'd15) begin
        n_bad++;
        $display("FAIL tlog%0d: got %0d want 15", i, log_cnt_t);
      end
    end
`endif
    go_t = 1'b1;
    step();
    go_t = 1'b0;
    n_total++;
    if (timeout_t !== 1'b0 || core_reset_t !== 1'b1 || prog_idx_t !== 2'd0) begin
      n_bad++;
      $display("FAIL timeout_clear: to=%b rst=%b idx=%0d, want 0 1 0", timeout_t, core_reset_t,
               prog_idx_t);
    end
    done_t = 1'b1;
    cyc = 0;
    while (all_done_t !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    done_t = 1'b0;
    n_total++;
    if (all_done_t !== 1'b1 || timeout_t !== 1'b0 || cycle_cnt_t !== 4'd1) begin
      n_bad++;
      $display("FAIL timeout_rerun: all_done=%b to=%b cnt=%0d, want 1 0 1", all_done_t,
               timeout_t, cycle_cnt_t);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 3; i++) lens[i] = int'($urandom_range(3, 8));
    run_series(1'b0, 1'b0, 1);
    // Table now reads zero; a fresh series must start again from program 0.
    for (int i = 0; i < 3; i++) lens[i] = int'($urandom_range(1, 6));
    run_series(1'b0, 1'b0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    go = 1'b0; done = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0;
    go_t = 1'b0; done_t = 1'b0; cfg_we_t = 1'b0; cfg_idx_t = '0; cfg_addr_t = '0;
`ifdef PROG_SEQ_CYCLE_LOG_EN
    log_idx = '0; log_idx_t = '0;
`endif
    for (int i = 0; i < 3; i++) model_base[i] = '0;
    test_reset();
    test_basic();
`ifdef PROG_SEQ_CYCLE_LOG_EN
    test_log();
`endif
    test_done_hold();
    test_random();
    test_timeout();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
